// File: rtl/cpu_defines.sv
// Shared CPU definitions: exception encodings, CP0 register map, ExcCodes,
// CP0 write masks and reset values.
package cpu_defines;

    typedef logic [5:0] Stall_t;
    localparam int STALL_MEM = 3;

    // Raised-exception flag positions, listed in selection priority order
    localparam int EV_INST_TLB_REFILL        = 0;
    localparam int EV_INST_TLB_INVALID       = 1;
    localparam int EV_INVALID_INST           = 2;
    localparam int EV_SYSCALL                = 3;
    localparam int EV_BREAKPOINT             = 4;
    localparam int EV_OV                     = 5;
    localparam int EV_DATA_TLB_REFILL_LOAD   = 6;
    localparam int EV_DATA_TLB_REFILL_STORE  = 7;
    localparam int EV_DATA_TLB_INVALID_LOAD  = 8;
    localparam int EV_DATA_TLB_INVALID_STORE = 9;
    localparam int EV_ERET                   = 10;
    localparam int EXCP_VEC_W                = 11;

    typedef logic [EXCP_VEC_W-1:0] Excp_vec_t;

    typedef enum logic [3:0] {
        EXC_NO                    = 4'd0,
        EXC_INTERRUPT             = 4'd1,
        EXC_INST_TLB_REFILL       = 4'd2,
        EXC_INST_TLB_INVALID      = 4'd3,
        EXC_INVALID_INST          = 4'd4,
        EXC_SYSCALL               = 4'd5,
        EXC_BREAKPOINT            = 4'd6,
        EXC_OV                    = 4'd7,
        EXC_DATA_TLB_REFILL_LOAD  = 4'd8,
        EXC_DATA_TLB_REFILL_STORE = 4'd9,
        EXC_DATA_TLB_INVALID_LOAD = 4'd10,
        EXC_DATA_TLB_INVALID_STORE = 4'd11,
        EXC_ERET                  = 4'd12
    } Excp_t;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;
    localparam logic [4:0] CP0_EBASE    = 5'd15;

    localparam logic [4:0] EXCCODE_INT  = 5'd0;
    localparam logic [4:0] EXCCODE_TLBL = 5'd2;
    localparam logic [4:0] EXCCODE_TLBS = 5'd3;
    localparam logic [4:0] EXCCODE_SYS  = 5'd8;
    localparam logic [4:0] EXCCODE_BP   = 5'd9;
    localparam logic [4:0] EXCCODE_RI   = 5'd10;
    localparam logic [4:0] EXCCODE_OV   = 5'd12;

    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
    localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;
    localparam logic [31:0] STATUS_RESET = 32'h0040_0000;
    localparam logic [31:0] CAUSE_RESET  = 32'h0000_0000;
    localparam logic [31:0] EBASE_RESET  = 32'h8000_0000;

    localparam int STATUS_IE_BIT  = 0;
    localparam int STATUS_EXL_BIT = 1;
    localparam int CAUSE_BD_BIT   = 31;

    function automatic logic [4:0] excp_code(input Excp_t t);
        logic [4:0] code;
        case (t)
            EXC_INST_TLB_REFILL, EXC_INST_TLB_INVALID,
            EXC_DATA_TLB_REFILL_LOAD, EXC_DATA_TLB_INVALID_LOAD:   code = EXCCODE_TLBL;
            EXC_DATA_TLB_REFILL_STORE, EXC_DATA_TLB_INVALID_STORE: code = EXCCODE_TLBS;
            EXC_INVALID_INST: code = EXCCODE_RI;
            EXC_SYSCALL:      code = EXCCODE_SYS;
            EXC_BREAKPOINT:   code = EXCCODE_BP;
            EXC_OV:           code = EXCCODE_OV;
            default:          code = EXCCODE_INT;
        endcase
        return code;
    endfunction

    function automatic logic excp_is_tlb(input Excp_t t);
        return (t == EXC_INST_TLB_REFILL)       || (t == EXC_INST_TLB_INVALID)      ||
               (t == EXC_DATA_TLB_REFILL_LOAD)  || (t == EXC_DATA_TLB_REFILL_STORE) ||
               (t == EXC_DATA_TLB_INVALID_LOAD) || (t == EXC_DATA_TLB_INVALID_STORE);
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// cp0_timer: free-running Count, Compare and sticky timer interrupt.
// Only built when CP0_TIMER_EN is defined.
`ifdef CP0_TIMER_EN
module cp0_timer
    import cpu_defines::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        timer_int_o
);

    logic wr_count;
    logic wr_compare;

    assign wr_count   = we_i && (waddr_i == CP0_COUNT);
    assign wr_compare = we_i && (waddr_i == CP0_COMPARE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_o     <= '0;
            compare_o   <= '0;
            timer_int_o <= 1'b0;
        end else begin
            count_o <= wr_count ? wdata_i : count_o + 32'd1;
            if (wr_compare) begin
                compare_o <= wdata_i;
            end
            // A Compare write acknowledges the interrupt and beats a same-cycle match
            if (wr_compare) begin
                timer_int_o <= 1'b0;
            end else if (count_o == compare_o) begin
                timer_int_o <= 1'b1;
            end
        end
    end

endmodule
`endif

// File: rtl/cp0_exc_unit.sv
// cp0_exc_unit: CP0 register file and exception prioritiser beside MEM.
// Define CP0_TIMER_EN to build the Count/Compare timer.
module cp0_exc_unit
    import cpu_defines::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  Stall_t      stall_i,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_pc_i,
    input  logic        in_delay_slot_i,
    input  Excp_vec_t   excp_vec_i,
    input  logic [31:0] bad_vaddr_i,
    input  logic [5:0]  hw_int_i,
    input  logic        cp0_we_i,
    input  logic [4:0]  cp0_waddr_i,
    input  logic [31:0] cp0_wdata_i,
    input  logic [4:0]  cp0_raddr_i,
    output logic [31:0] cp0_rdata_o,
    output Excp_t       exception_type_o,
    output logic [31:0] cp0_epc_o,
    output logic [31:0] cp0_ebase_o,
    output logic        timer_int_o
);

    logic [31:0] status_q, cause_q, epc_q, badvaddr_q, ebase_q;
    logic [31:0] status_d, cause_d, epc_d, badvaddr_d, ebase_d;
    logic [31:0] status_byp, cause_byp, epc_byp, badvaddr_byp, ebase_byp;
    logic [31:0] count_rd, compare_rd;
    logic        timer_int;
    logic        wr_badvaddr, wr_status, wr_cause, wr_epc, wr_ebase;
    logic        int_pending;
    logic        commit;
    Excp_t       excp_sel;
    logic        unused_stall;

    assign unused_stall = ^{stall_i[5:4], stall_i[2:0]};

    assign wr_badvaddr = cp0_we_i && (cp0_waddr_i == CP0_BADVADDR);
    assign wr_status   = cp0_we_i && (cp0_waddr_i == CP0_STATUS);
    assign wr_cause    = cp0_we_i && (cp0_waddr_i == CP0_CAUSE);
    assign wr_epc      = cp0_we_i && (cp0_waddr_i == CP0_EPC);
    assign wr_ebase    = cp0_we_i && (cp0_waddr_i == CP0_EBASE);

    // Same-cycle MTC0 forwarded into reads, interrupt detection and next state
    assign status_byp   = wr_status ? ((status_q & ~STATUS_WMASK) | (cp0_wdata_i & STATUS_WMASK))
                                    : status_q;
    assign cause_byp    = wr_cause ? ((cause_q & ~CAUSE_WMASK) | (cp0_wdata_i & CAUSE_WMASK))
                                   : cause_q;
    assign epc_byp      = wr_epc      ? cp0_wdata_i : epc_q;
    assign badvaddr_byp = wr_badvaddr ? cp0_wdata_i : badvaddr_q;
    assign ebase_byp    = wr_ebase    ? cp0_wdata_i : ebase_q;

`ifdef CP0_TIMER_EN
    logic [31:0] count_q;
    logic [31:0] compare_q;

    cp0_timer u_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .we_i        (cp0_we_i),
        .waddr_i     (cp0_waddr_i),
        .wdata_i     (cp0_wdata_i),
        .count_o     (count_q),
        .compare_o   (compare_q),
        .timer_int_o (timer_int)
    );

    assign count_rd   = (cp0_we_i && (cp0_waddr_i == CP0_COUNT))   ? cp0_wdata_i : count_q;
    assign compare_rd = (cp0_we_i && (cp0_waddr_i == CP0_COMPARE)) ? cp0_wdata_i : compare_q;
`else
    assign count_rd   = '0;
    assign compare_rd = '0;
    assign timer_int  = 1'b0;
`endif

    assign timer_int_o = timer_int;

    assign int_pending = (|(cause_byp[15:8] & status_byp[15:8])) &&
                         status_byp[STATUS_IE_BIT] && !status_byp[STATUS_EXL_BIT];

    always_comb begin
        excp_sel = EXC_NO;
        if (mem_valid_i) begin
            if (int_pending)                                  excp_sel = EXC_INTERRUPT;
            else if (excp_vec_i[EV_INST_TLB_REFILL])          excp_sel = EXC_INST_TLB_REFILL;
            else if (excp_vec_i[EV_INST_TLB_INVALID])         excp_sel = EXC_INST_TLB_INVALID;
            else if (excp_vec_i[EV_INVALID_INST])             excp_sel = EXC_INVALID_INST;
            else if (excp_vec_i[EV_SYSCALL])                  excp_sel = EXC_SYSCALL;
            else if (excp_vec_i[EV_BREAKPOINT])               excp_sel = EXC_BREAKPOINT;
            else if (excp_vec_i[EV_OV])                       excp_sel = EXC_OV;
            else if (excp_vec_i[EV_DATA_TLB_REFILL_LOAD])     excp_sel = EXC_DATA_TLB_REFILL_LOAD;
            else if (excp_vec_i[EV_DATA_TLB_REFILL_STORE])    excp_sel = EXC_DATA_TLB_REFILL_STORE;
            else if (excp_vec_i[EV_DATA_TLB_INVALID_LOAD])    excp_sel = EXC_DATA_TLB_INVALID_LOAD;
            else if (excp_vec_i[EV_DATA_TLB_INVALID_STORE])   excp_sel = EXC_DATA_TLB_INVALID_STORE;
            else if (excp_vec_i[EV_ERET])                     excp_sel = EXC_ERET;
        end
    end

    assign exception_type_o = excp_sel;
    assign commit           = (excp_sel != EXC_NO) && !stall_i[STALL_MEM];
    assign cp0_epc_o        = epc_byp;
    assign cp0_ebase_o      = ebase_byp;

    always_comb begin
        cp0_rdata_o = '0;
        case (cp0_raddr_i)
            CP0_BADVADDR: cp0_rdata_o = badvaddr_byp;
            CP0_COUNT:    cp0_rdata_o = count_rd;
            CP0_COMPARE:  cp0_rdata_o = compare_rd;
            CP0_STATUS:   cp0_rdata_o = status_byp;
            CP0_CAUSE:    cp0_rdata_o = cause_byp;
            CP0_EPC:      cp0_rdata_o = epc_byp;
            CP0_EBASE:    cp0_rdata_o = ebase_byp;
            default:      cp0_rdata_o = '0;
        endcase
    end

    // MTC0 lands first; commit then overrides only the fields it owns
    always_comb begin
        status_d    = status_byp;
        cause_d     = cause_byp;
        epc_d       = epc_byp;
        badvaddr_d  = badvaddr_byp;
        ebase_d     = ebase_byp;
        cause_d[15:10] = {hw_int_i[5] | timer_int, hw_int_i[4:0]};
        if (commit) begin
            if (excp_sel == EXC_ERET) begin
                status_d[STATUS_EXL_BIT] = 1'b0;
            end else begin
                // A nested exception keeps the original return point
                if (!status_byp[STATUS_EXL_BIT]) begin
                    epc_d                 = in_delay_slot_i ? (mem_pc_i - 32'd4) : mem_pc_i;
                    cause_d[CAUSE_BD_BIT] = in_delay_slot_i;
                end
                status_d[STATUS_EXL_BIT] = 1'b1;
                cause_d[6:2]             = excp_code(excp_sel);
                if (excp_is_tlb(excp_sel)) begin
                    badvaddr_d = bad_vaddr_i;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_q   <= STATUS_RESET;
            cause_q    <= CAUSE_RESET;
            epc_q      <= '0;
            badvaddr_q <= '0;
            ebase_q    <= EBASE_RESET;
        end else begin
            status_q   <= status_d;
            cause_q    <= cause_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
            ebase_q    <= ebase_d;
        end
    end

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Self-checking bench for cp0_exc_unit: directed scenarios plus randomized
// traffic against a field-level CP0 reference model.
module tb_cp0_exc_unit;
    import cpu_defines::*;

    logic        clk = 1'b0;
    logic        rst_n;
    Stall_t      stall;
    logic        mem_valid;
    logic [31:0] mem_pc;
    logic        in_ds;
    Excp_vec_t   excp_vec;
    logic [31:0] bad_vaddr;
    logic [5:0]  hw_int;
    logic        cp0_we;
    logic [4:0]  cp0_waddr;
    logic [31:0] cp0_wdata;
    logic [4:0]  cp0_raddr;
    logic [31:0] cp0_rdata;
    Excp_t       exc_type;
    logic [31:0] cp0_epc;
    logic [31:0] cp0_ebase;
    logic        timer_int;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cp0_exc_unit dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall_i          (stall),
        .mem_valid_i      (mem_valid),
        .mem_pc_i         (mem_pc),
        .in_delay_slot_i  (in_ds),
        .excp_vec_i       (excp_vec),
        .bad_vaddr_i      (bad_vaddr),
        .hw_int_i         (hw_int),
        .cp0_we_i         (cp0_we),
        .cp0_waddr_i      (cp0_waddr),
        .cp0_wdata_i      (cp0_wdata),
        .cp0_raddr_i      (cp0_raddr),
        .cp0_rdata_o      (cp0_rdata),
        .exception_type_o (exc_type),
        .cp0_epc_o        (cp0_epc),
        .cp0_ebase_o      (cp0_ebase),
        .timer_int_o      (timer_int)
    );

    // Reference model state, kept as architectural fields
    logic [7:0]  m_im;
    logic        m_exl, m_ie, m_bd, m_timer;
    logic [4:0]  m_code;
    logic [1:0]  m_ipsw;
    logic [5:0]  m_iphw;
    logic [31:0] m_epc, m_badv, m_ebase, m_count, m_compare;

    logic [7:0]  e_im;
    logic        e_exl, e_ie;
    logic [1:0]  e_ipsw;
    Excp_t       exp_type;
    logic [31:0] exp_rdata, exp_epc, exp_ebase, exp_badv;
    logic        exp_timer;

    Excp_t prio_tbl [11] = '{EXC_INST_TLB_REFILL, EXC_INST_TLB_INVALID, EXC_INVALID_INST,
                             EXC_SYSCALL, EXC_BREAKPOINT, EXC_OV,
                             EXC_DATA_TLB_REFILL_LOAD, EXC_DATA_TLB_REFILL_STORE,
                             EXC_DATA_TLB_INVALID_LOAD, EXC_DATA_TLB_INVALID_STORE, EXC_ERET};

    function automatic logic wr(input logic [4:0] a);
        return cp0_we && (cp0_waddr == a);
    endfunction

    function automatic logic [4:0] code_of(input Excp_t t);
        case (t)
            EXC_INTERRUPT:                                         return 5'd0;
            EXC_INST_TLB_REFILL, EXC_INST_TLB_INVALID:             return 5'd2;
            EXC_DATA_TLB_REFILL_LOAD, EXC_DATA_TLB_INVALID_LOAD:   return 5'd2;
            EXC_DATA_TLB_REFILL_STORE, EXC_DATA_TLB_INVALID_STORE: return 5'd3;
            EXC_SYSCALL:                                           return 5'd8;
            EXC_BREAKPOINT:                                        return 5'd9;
            EXC_INVALID_INST:                                      return 5'd10;
            EXC_OV:                                                return 5'd12;
            default:                                               return 5'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_im = '0; m_exl = 1'b0; m_ie = 1'b0; m_bd = 1'b0; m_timer = 1'b0;
        m_code = '0; m_ipsw = '0; m_iphw = '0;
        m_epc = '0; m_badv = '0; m_ebase = 32'h8000_0000; m_count = '0; m_compare = '0;
    endtask

    task automatic model_comb();
        logic [7:0]  ip;
        logic        pend;
        logic [31:0] cnt, cmp;
        e_im   = wr(5'd12) ? cp0_wdata[15:8] : m_im;
        e_exl  = wr(5'd12) ? cp0_wdata[1]    : m_exl;
        e_ie   = wr(5'd12) ? cp0_wdata[0]    : m_ie;
        e_ipsw = wr(5'd13) ? cp0_wdata[9:8]  : m_ipsw;
        ip   = {m_iphw, e_ipsw};
        pend = ((ip & e_im) != 8'd0) && e_ie && !e_exl;
        exp_type = EXC_NO;
        if (mem_valid) begin
            if (pend) exp_type = EXC_INTERRUPT;
            else begin
                for (int i = 0; i < 11; i++)
                    if (excp_vec[i] && exp_type == EXC_NO) exp_type = prio_tbl[i];
            end
        end
        exp_epc   = wr(5'd14) ? cp0_wdata : m_epc;
        exp_ebase = wr(5'd15) ? cp0_wdata : m_ebase;
        exp_badv  = wr(5'd8)  ? cp0_wdata : m_badv;
`ifdef CP0_TIMER_EN
        cnt = wr(5'd9)  ? cp0_wdata : m_count;
        cmp = wr(5'd11) ? cp0_wdata : m_compare;
`else
        cnt = '0;
        cmp = '0;
`endif
        case (cp0_raddr)
            5'd8:    exp_rdata = exp_badv;
            5'd9:    exp_rdata = cnt;
            5'd11:   exp_rdata = cmp;
            5'd12:   exp_rdata = {9'd0, 1'b1, 6'd0, e_im, 6'd0, e_exl, e_ie};
            5'd13:   exp_rdata = {m_bd, 15'd0, m_iphw, e_ipsw, 1'b0, m_code, 2'b00};
            5'd14:   exp_rdata = exp_epc;
            5'd15:   exp_rdata = exp_ebase;
            default: exp_rdata = '0;
        endcase
        exp_timer = m_timer;
    endtask

    task automatic model_update();
        logic t_now;
        if (!rst_n) begin
            model_reset();
        end else begin
            model_comb();
            t_now = m_timer;
`ifdef CP0_TIMER_EN
            if (wr(5'd11)) m_timer = 1'b0;
            else if (m_count == m_compare) m_timer = 1'b1;
            m_count = wr(5'd9) ? cp0_wdata : m_count + 32'd1;
            if (wr(5'd11)) m_compare = cp0_wdata;
`endif
            m_iphw = {hw_int[5] | t_now, hw_int[4:0]};
            m_im = e_im; m_exl = e_exl; m_ie = e_ie; m_ipsw = e_ipsw;
            m_epc = exp_epc; m_ebase = exp_ebase; m_badv = exp_badv;
            if (exp_type != EXC_NO && !stall[3]) begin
                if (exp_type == EXC_ERET) begin
                    m_exl = 1'b0;
                end else begin
                    if (!e_exl) begin
                        m_epc = in_ds ? mem_pc - 32'd4 : mem_pc;
                        m_bd  = in_ds;
                    end
                    m_exl  = 1'b1;
                    m_code = code_of(exp_type);
                    if (exp_type inside {EXC_INST_TLB_REFILL, EXC_INST_TLB_INVALID,
                                         EXC_DATA_TLB_REFILL_LOAD, EXC_DATA_TLB_REFILL_STORE,
                                         EXC_DATA_TLB_INVALID_LOAD, EXC_DATA_TLB_INVALID_STORE})
                        m_badv = bad_vaddr;
                end
            end
        end
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        stall = '0; mem_valid = 1'b0; mem_pc = '0; in_ds = 1'b0; excp_vec = '0;
        bad_vaddr = '0; hw_int = '0; cp0_we = 1'b0; cp0_waddr = '0; cp0_wdata = '0;
        cp0_raddr = '0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        cp0_we = 1'b1; cp0_waddr = a; cp0_wdata = d;
    endtask

    task automatic apply_reset();
        drive_idle();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [4:0]  addrs [9] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd0, 5'd31};
        logic [31:0] expv;
        drive_idle();
        rst_n = 1'b0;
        #2;
        for (int i = 0; i < 9; i++) begin
            cp0_raddr = addrs[i];
            #1;
            expv = (addrs[i] == 5'd12) ? 32'h0040_0000 : (addrs[i] == 5'd15) ? 32'h8000_0000 : 32'h0;
            total++;
            if (cp0_rdata !== expv) begin
                bad++;
                $display("FAIL reset_rdata addr=%0d got=%h exp=%h", addrs[i], cp0_rdata, expv);
            end
        end
        total++;
        if (timer_int !== 1'b0) begin bad++; $display("FAIL reset_timer got=%b exp=0", timer_int); end
        total++;
        if (cp0_epc !== 32'h0) begin bad++; $display("FAIL reset_epc got=%h exp=0", cp0_epc); end
        total++;
        if (cp0_ebase !== 32'h8000_0000) begin bad++; $display("FAIL reset_ebase got=%h exp=80000000", cp0_ebase); end
        total++;
        if (exc_type !== EXC_NO) begin bad++; $display("FAIL reset_type got=%0d exp=%0d", exc_type, EXC_NO); end
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_syscall();
        apply_reset();
        mem_valid = 1'b1; mem_pc = 32'h8000_0100; excp_vec[EV_SYSCALL] = 1'b1;
        #2;
        total++;
        if (exc_type !== EXC_SYSCALL) begin bad++; $display("FAIL syscall_type got=%0d exp=%0d", exc_type, EXC_SYSCALL); end
        tick();
        drive_idle();
        cp0_raddr = 5'd14; #1;
        total++;
        if (cp0_rdata !== 32'h8000_0100) begin bad++; $display("FAIL syscall_epc got=%h exp=80000100", cp0_rdata); end
        cp0_raddr = 5'd12; #1;
        total++;
        if (cp0_rdata[1] !== 1'b1) begin bad++; $display("FAIL syscall_exl got=%b exp=1", cp0_rdata[1]); end
        cp0_raddr = 5'd13; #1;
        total++;
        if (cp0_rdata[6:2] !== 5'd8) begin bad++; $display("FAIL syscall_code got=%0d exp=8", cp0_rdata[6:2]); end
    endtask

    task automatic test_delay_slot_ov();
        apply_reset();
        mem_valid = 1'b1; mem_pc = 32'h8000_0204; in_ds = 1'b1; excp_vec[EV_OV] = 1'b1;
        #2;
        total++;
        if (exc_type !== EXC_OV) begin bad++; $display("FAIL ds_ov_type got=%0d exp=%0d", exc_type, EXC_OV); end
        tick();
        drive_idle();
        cp0_raddr = 5'd13; #1;
        total++;
        if (cp0_epc !== 32'h8000_0200) begin bad++; $display("FAIL ds_ov_epc got=%h exp=80000200", cp0_epc); end
        total++;
        if (cp0_rdata[31] !== 1'b1) begin bad++; $display("FAIL ds_ov_bd got=%b exp=1", cp0_rdata[31]); end
        total++;
        if (cp0_rdata[6:2] !== 5'd12) begin bad++; $display("FAIL ds_ov_code got=%0d exp=12", cp0_rdata[6:2]); end
        mem_valid = 1'b1; mem_pc = 32'h8000_0300; excp_vec[EV_ERET] = 1'b1;
        #1;
        total++;
        if (exc_type !== EXC_ERET) begin bad++; $display("FAIL eret_type got=%0d exp=%0d", exc_type, EXC_ERET); end
        tick();
        drive_idle();
        cp0_raddr = 5'd12; #1;
        total++;
        if (cp0_rdata[1] !== 1'b0) begin bad++; $display("FAIL eret_exl got=%b exp=0", cp0_rdata[1]); end
        total++;
        if (cp0_epc !== 32'h8000_0200) begin bad++; $display("FAIL eret_epc got=%h exp=80000200", cp0_epc); end
    endtask

    task automatic test_priority_stall();
        apply_reset();
        mem_valid = 1'b1; mem_pc = 32'h8000_0400; stall = 6'b001000;
        excp_vec[EV_INVALID_INST] = 1'b1; excp_vec[EV_OV] = 1'b1;
        cp0_raddr = 5'd13;
        #2;
        total++;
        if (exc_type !== EXC_INVALID_INST) begin bad++; $display("FAIL prio_type got=%0d exp=%0d", exc_type, EXC_INVALID_INST); end
        tick();
        tick();
        total++;
        if (exc_type !== EXC_INVALID_INST) begin bad++; $display("FAIL prio_hold_type got=%0d exp=%0d", exc_type, EXC_INVALID_INST); end
        total++;
        if (cp0_epc !== 32'h0) begin bad++; $display("FAIL stall_epc got=%h exp=0", cp0_epc); end
        total++;
        if (cp0_rdata[6:2] !== 5'd0 || cp0_rdata[31] !== 1'b0) begin
            bad++; $display("FAIL stall_cause got=%h exp code=0 bd=0", cp0_rdata);
        end
        stall = '0;
        tick();
        drive_idle();
        cp0_raddr = 5'd13; #1;
        total++;
        if (cp0_rdata[6:2] !== 5'd10) begin bad++; $display("FAIL release_code got=%0d exp=10", cp0_rdata[6:2]); end
        total++;
        if (cp0_epc !== 32'h8000_0400) begin bad++; $display("FAIL release_epc got=%h exp=80000400", cp0_epc); end
    endtask

    task automatic test_interrupt();
        apply_reset();
        mtc0(5'd12, 32'h0000_0401);
        tick();
        cp0_we = 1'b0;
        hw_int = 6'b000001; mem_valid = 1'b1; mem_pc = 32'h8000_1000;
        #1;
        total++;
        if (exc_type !== EXC_NO) begin bad++; $display("FAIL int_early got=%0d exp=%0d", exc_type, EXC_NO); end
        tick();
        total++;
        if (exc_type !== EXC_INTERRUPT) begin bad++; $display("FAIL int_taken got=%0d exp=%0d", exc_type, EXC_INTERRUPT); end
        tick();
        total++;
        if (exc_type !== EXC_NO) begin bad++; $display("FAIL int_exl_masked got=%0d exp=%0d", exc_type, EXC_NO); end
        cp0_raddr = 5'd13; #1;
        total++;
        if (cp0_rdata[6:2] !== 5'd0 || cp0_epc !== 32'h8000_1000) begin
            bad++; $display("FAIL int_commit got cause=%h epc=%h exp code=0 epc=80001000", cp0_rdata, cp0_epc);
        end
        drive_idle();
    endtask

    task automatic test_timer();
        apply_reset();
`ifdef CP0_TIMER_EN
        mtc0(5'd9, 32'd100);  tick();
        mtc0(5'd11, 32'd5);   tick();
        mtc0(5'd9, 32'd0);    tick();
        cp0_we = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            #1;
            total++;
            if (timer_int !== ((k == 6) ? 1'b1 : 1'b0)) begin
                bad++; $display("FAIL timer_edge k=%0d got=%b exp=%b", k, timer_int, (k == 6));
            end
        end
        mtc0(5'd11, 32'd1000);
        tick();
        cp0_we = 1'b0;
        #1;
        total++;
        if (timer_int !== 1'b0) begin bad++; $display("FAIL timer_clear got=%b exp=0", timer_int); end
`else
        mtc0(5'd11, 32'd5); tick();
        mtc0(5'd9, 32'd0);  tick();
        cp0_we = 1'b0; cp0_raddr = 5'd9;
        for (int k = 1; k <= 8; k++) begin
            tick();
            #1;
            total++;
            if (timer_int !== 1'b0 || cp0_rdata !== 32'h0) begin
                bad++; $display("FAIL timer_off k=%0d got int=%b count=%h exp 0", k, timer_int, cp0_rdata);
            end
        end
`endif
    endtask

    task automatic test_collision();
        apply_reset();
        mtc0(5'd14, 32'h0000_1234);
        mem_valid = 1'b1; mem_pc = 32'h0000_0040; bad_vaddr = 32'hDEAD_B000;
        excp_vec[EV_INST_TLB_REFILL] = 1'b1;
        #2;
        total++;
        if (cp0_epc !== 32'h0000_1234) begin bad++; $display("FAIL coll_bypass got=%h exp=00001234", cp0_epc); end
        total++;
        if (exc_type !== EXC_INST_TLB_REFILL) begin bad++; $display("FAIL coll_type got=%0d exp=%0d", exc_type, EXC_INST_TLB_REFILL); end
        tick();
        drive_idle();
        cp0_raddr = 5'd8; #1;
        total++;
        if (cp0_epc !== 32'h0000_0040) begin bad++; $display("FAIL coll_epc got=%h exp=00000040", cp0_epc); end
        total++;
        if (cp0_rdata !== 32'hDEAD_B000) begin bad++; $display("FAIL coll_badvaddr got=%h exp=deadb000", cp0_rdata); end
        cp0_raddr = 5'd13; #1;
        total++;
        if (cp0_rdata[6:2] !== 5'd2) begin bad++; $display("FAIL coll_code got=%0d exp=2", cp0_rdata[6:2]); end
    endtask

    task automatic test_random();
        logic [4:0]  addrs [8] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd3};
        logic [31:0] r;
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            mem_valid = ($urandom_range(0, 1) == 1);
            r = $urandom();
            mem_pc = r & 32'hFFFF_FFFC;
            in_ds = ($urandom_range(0, 1) == 1);
            excp_vec = '0;
            for (int i = 0; i < 11; i++) excp_vec[i] = ($urandom_range(0, 9) == 0);
            stall = 6'($urandom());
            stall[3] = ($urandom_range(0, 3) == 0);
            hw_int = ($urandom_range(0, 3) == 0) ? 6'($urandom()) : 6'd0;
            cp0_we = ($urandom_range(0, 2) == 0);
            cp0_waddr = addrs[$urandom_range(0, 7)];
            cp0_wdata = $urandom();
            cp0_raddr = addrs[$urandom_range(0, 7)];
            bad_vaddr = $urandom();
            #2;
            model_comb();
            total++;
            if (exc_type !== exp_type) begin bad++; $display("FAIL rnd_type n=%0d got=%0d exp=%0d", n, exc_type, exp_type); end
            total++;
            if (cp0_rdata !== exp_rdata) begin bad++; $display("FAIL rnd_rdata n=%0d addr=%0d got=%h exp=%h", n, cp0_raddr, cp0_rdata, exp_rdata); end
            total++;
            if (cp0_epc !== exp_epc) begin bad++; $display("FAIL rnd_epc n=%0d got=%h exp=%h", n, cp0_epc, exp_epc); end
            total++;
            if (cp0_ebase !== exp_ebase) begin bad++; $display("FAIL rnd_ebase n=%0d got=%h exp=%h", n, cp0_ebase, exp_ebase); end
            total++;
            if (timer_int !== exp_timer) begin bad++; $display("FAIL rnd_timer n=%0d got=%b exp=%b", n, timer_int, exp_timer); end
            tick();
        end
    endtask

    task automatic test_async_reset();
        drive_idle();
        mtc0(5'd14, 32'h0000_ABCD);
        tick();
        mtc0(5'd15, 32'h1234_0000);
        tick();
        drive_idle();
        #2;
        rst_n = 1'b0;
        cp0_raddr = 5'd12;
        #1;
        total++;
        if (cp0_epc !== 32'h0) begin bad++; $display("FAIL areset_epc got=%h exp=0", cp0_epc); end
        total++;
        if (cp0_ebase !== 32'h8000_0000) begin bad++; $display("FAIL areset_ebase got=%h exp=80000000", cp0_ebase); end
        total++;
        if (cp0_rdata !== 32'h0040_0000) begin bad++; $display("FAIL areset_status got=%h exp=00400000", cp0_rdata); end
        total++;
        if (timer_int !== 1'b0) begin bad++; $display("FAIL areset_timer got=%b exp=0", timer_int); end
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_syscall();
        test_delay_slot_ov();
        test_priority_stall();
        test_interrupt();
        test_timer();
        test_collision();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cp0_exc_unit.md
# cp0_exc_unit

Coprocessor-0 register file and exception prioritiser sitting beside the MEM stage. Collects per-instruction exception flags, pending interrupts and ERET, selects the single highest-priority exception as `exception_type_o` for the pipeline controller, and commits EPC/Status/Cause/BadVAddr on the cycle the faulting instruction leaves MEM. It also supplies `cp0_ebase_o` and `cp0_epc_o`, which the controller uses to form the redirect PC, and serves MFC0 reads and MTC0 writes.

## Interface
- No parameters.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `stall_i` in `Stall_t` (6): pipeline stall vector; bit 3 = MEM stalled.
- `mem_valid_i` in 1: MEM holds a real instruction (not a bubble).
- `mem_pc_i` in 32: PC of the MEM instruction.
- `in_delay_slot_i` in 1: MEM instruction is in a branch delay slot.
- `excp_vec_i` in `Excp_vec_t` (11): raised-exception flags from earlier stages.
- `bad_vaddr_i` in 32: faulting address for TLB exceptions.
- `hw_int_i` in 6: external interrupt lines, level-sensitive.
- `cp0_we_i` in 1: MTC0 write enable, from WB.
- `cp0_waddr_i` in 5: MTC0 write address.
- `cp0_wdata_i` in 32: MTC0 write data.
- `cp0_raddr_i` in 5: MFC0 read address.
- `cp0_rdata_o` out 32: MFC0 read data.
- `exception_type_o` out `Excp_t`: selected exception, or `EXC_NO`.
- `cp0_epc_o` out 32: effective EPC.
- `cp0_ebase_o` out 32: effective EBase.
- `timer_int_o` out 1: timer interrupt pending.

## Operation
- **Registers and addresses:** BadVAddr (8), Count (9), Compare (11), Status (12), Cause (13), EPC (14), EBase (15). Any other read address returns 0.
- **Reset values:**
  - Status = 0x0040_0000 (BEV=1).
  - EBase = 0x8000_0000.
  - All other registers = 0.
  - `timer_int_o` = 0.
- **Writable masks:**
  - Status: IM[15:8], EXL[1], IE[0].
  - Cause: IP[9:8] only.
  - EPC, BadVAddr, Count, Compare, EBase: all 32 bits.
- **Cause.IP sampling:** Cause.IP[7:2] is resampled every cycle as `hw_int_i`, with IP7 ORed with `timer_int_o`.
- **Interrupt pending:** `(Cause.IP & Status.IM) != 0 && IE && !EXL`.
- **Selection:** when `mem_valid_i` = 0, `exception_type_o` = `EXC_NO`. Otherwise, in priority order:
  1. INTERRUPT
  2. INST_TLB_REFILL
  3. INST_TLB_INVALID
  4. INVALID_INST
  5. SYSCALL
  6. BREAKPOINT
  7. OV
  8. DATA_TLB_REFILL_LOAD/STORE
  9. DATA_TLB_INVALID_LOAD/STORE
  10. ERET
- **Commit condition:** `exception_type_o` ≠ `EXC_NO` and `stall_i[3]` = 0.
- **Commit, non-ERET:**
  - If EXL = 0: EPC = `in_delay_slot_i` ? `mem_pc_i` − 4 : `mem_pc_i`, and Cause.BD = `in_delay_slot_i`. If EXL = 1, EPC and BD are held.
  - EXL ← 1.
  - Cause.ExcCode: Int 0, TLBL 2, TLBS 3, Sys 8, Bp 9, RI 10, Ov 12. Refill and invalid use the same code.
  - TLB types also load BadVAddr ← `bad_vaddr_i`.
- **Commit, ERET:** EXL ← 0; nothing else changes.
- **MTC0 and commit in the same cycle:** commit wins on every field it writes; the MTC0 applies to all other bits.
- **Write bypass:**
  - `cp0_rdata_o`, `cp0_epc_o` and `cp0_ebase_o` forward a same-cycle MTC0 to the matching address.
  - The interrupt-pending term uses the bypassed Status and Cause.
- **Outputs while MEM is stalled:** `exception_type_o` stays valid, but no state changes.

## Timing
- `exception_type_o`, `cp0_rdata_o`, `cp0_epc_o` and `cp0_ebase_o` are combinational, with zero latency.
- CP0 state updates on the rising edge after the commit condition holds.
- An interrupt raised on `hw_int_i` is visible in Cause one cycle later, and can be taken from the next valid MEM instruction onward.
- Count increments every cycle and wraps 0xFFFF_FFFF → 0. An MTC0 to Count loads the written value and does not increment that cycle.
- When Count == Compare, `timer_int_o` goes to 1 on the next edge and is sticky.
- An MTC0 to Compare clears `timer_int_o`; the clear wins over a simultaneous set.
- Asserting `rst_n` mid-operation returns every register to its reset value immediately.

## Configuration
- `CP0_TIMER_EN`:
  - Defined: Count/Compare and `timer_int_o` behave as above.
  - Undefined: Count and Compare read 0, writes to them are ignored, `timer_int_o` is tied 0, and IP7 = `hw_int_i[5]` only.

## Structure
- Shared package `cpu_defines` holds:
  - the `Excp_t` enum, `Excp_vec_t` and its bit indices;
  - CP0 register address constants, ExcCode constants and write masks;
  - the Status/Cause reset values.
- Natural sub-module: `cp0_timer` (Count/Compare/timer_int), instantiated only under `CP0_TIMER_EN`.

## Test plan
- **Syscall:** reset; MEM valid, PC 0x8000_0100, SYSCALL flag, not in delay slot → `exception_type_o` = `EXC_SYSCALL`; after the edge, EPC = 0x8000_0100, EXL = 1, ExcCode = 8.
- **Delay-slot OV:** OV flag with `in_delay_slot_i` = 1, PC 0x8000_0204 → EPC = 0x8000_0200, BD = 1, ExcCode = 12; then ERET → EXL = 0.
- **Priority and stall hold:** RI and OV raised together with `stall_i[3]` = 1 → type is `INVALID_INST` and no state change; release stall → commit, ExcCode = 10.
- **Interrupt:** Status = 0x0000_0401 written, then `hw_int_i[0]` = 1 → `EXC_INTERRUPT` on the next valid instruction. With EXL = 1 the same stimulus gives `EXC_NO`.
- **Timer:** Compare = 5 and Count = 0 → `timer_int_o` = 1 six cycles after the Count write; write Compare → 0 next cycle. With the macro off, it stays 0 throughout.
- **MTC0/commit collision:** MTC0 EPC = 0x1234 in the same cycle as a TLB refill at PC 0x40 → EPC = 0x40 and BadVAddr = `bad_vaddr_i`.
